// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Imported by hazard_ctrl and forward_sel.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] RESULT_MEM = 2'b01;

endpackage

// File: rtl/forward_sel.sv
// One-operand forwarding comparator for the execute stage.
// The memory stage wins over writeback; x0 never forwards.
module forward_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rd_m,
  input  logic [ADDR_WIDTH-1:0] rd_w,
  input  logic [2:0]            reg_write_m,
  input  logic [2:0]            reg_write_w,
  output logic [1:0]            fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = (reg_write_m != '0) &&
                 (rd_m != '0) &&
                 (rd_m == rs);
  assign hit_w = (reg_write_w != '0) &&
                 (rd_w != '0) &&
                 (rd_w == rs);

  always_comb begin
    fwd = FWD_NONE;
    if (hit_m)
      fwd = FWD_MEM;
    else if (hit_w)
      fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: register enables/clears, forwarding
// selects and a data-memory wait FSM with sticky timeout flag.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] Rs1E,
  input  logic [ADDR_WIDTH-1:0] Rs2E,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [2:0]            RegWriteM,
  input  logic [2:0]            RegWriteW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  mem_ready,
  output logic                  EnF,
  output logic                  EnD,
  output logic                  EnE,
  output logic                  EnM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  mem_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_WIDTH-1:0]   wait_cnt;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic                   lw_stall;
  logic                   mem_hold;

  forward_sel #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  forward_sel #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  assign ForwardAE = rst_n ? fwd_a : FWD_NONE;
  assign ForwardBE = rst_n ? fwd_b : FWD_NONE;

  assign lw_stall = (ResultSrcE == RESULT_MEM) &&
                    (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Freeze whole pipe: new miss in RUN, or still waiting
  assign mem_hold = !mem_ready &&
                    ((state == MEM_WAIT) || MemReqM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == MEM_WAIT && !mem_ready) begin
        if (wait_cnt != CNT_MAX)
          wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == CNT_LAST)
          mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    EnF      = 1'b1;
    EnD      = 1'b1;
    EnE      = 1'b1;
    EnM      = 1'b1;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_hold) begin
      state_nx = MEM_WAIT;
      EnF      = 1'b0;
      EnD      = 1'b0;
      EnE      = 1'b0;
      EnM      = 1'b0;
      FlushW   = 1'b1;
    end else begin
      state_nx = RUN;
      if (lw_stall && !PCSrcE) begin
        EnF    = 1'b0;
        EnD    = 1'b0;
        FlushE = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [2:0] RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemReqM, mem_ready;
  logic       EnF, EnD, EnE, EnM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_err;

  typedef struct {
    string       name;
    logic [13:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .ADDR_WIDTH  (5),
    .MEM_TIMEOUT (4),
    .CNT_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .mem_ready  (mem_ready),
    .EnF        (EnF),
    .EnD        (EnD),
    .EnE        (EnE),
    .EnM        (EnM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .mem_err    (mem_err)
  );

  // {EnF,EnD,EnE,EnM}{FlushD,FlushE,FlushW}{FwdA}{FwdB}{err}
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [13:0] got;
      e   = q.pop_front();
      got = {EnF, EnD, EnE, EnM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, mem_err};
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL %s got=%b want=%b", e.name, got, e.val);
      end
    end
  end

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
    RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
    PCSrcE = 0; MemReqM = 0; mem_ready = 0;
  endtask

  task automatic chk(input string name,
                     input logic [3:0] en,
                     input logic [2:0] fl,
                     input logic [1:0] fa,
                     input logic [1:0] fb,
                     input logic       err);
    exp_t e;
    e.name = name;
    e.val  = {en, fl, fa, fb, err};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // reset: forwards masked even with a match present
    Rs1E = 5; RdM = 5; RegWriteM = 1;
    chk("reset", 4'hF, 3'b111, 2'b00, 2'b00, 1'b0);

    rst_n = 1'b1;
    RdW = 5; RegWriteW = 1;
    chk("fwd_mem", 4'hF, 3'b000, 2'b10, 2'b00, 1'b0);
    RegWriteM = 0;
    chk("fwd_wb", 4'hF, 3'b000, 2'b01, 2'b00, 1'b0);
    Rs1E = 0; Rs2E = 5;
    chk("fwd_x0_b_wb", 4'hF, 3'b000, 2'b00, 2'b01, 1'b0);
    RdM = 5; RegWriteM = 3; Rs1E = 5;
    chk("fwd_both_mem", 4'hF, 3'b000, 2'b10, 2'b10, 1'b0);
    RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    RegWriteM = 1; RegWriteW = 7;
    chk("fwd_rd_x0", 4'hF, 3'b000, 2'b00, 2'b00, 1'b0);

    clr();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    chk("lw_stall", 4'b0011, 3'b010, 2'b00, 2'b00, 1'b0);
    ResultSrcE = 0; RdE = 0;
    chk("lw_bubble", 4'hF, 3'b000, 2'b00, 2'b00, 1'b0);
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
    chk("lw_x0", 4'hF, 3'b000, 2'b00, 2'b00, 1'b0);
    RdE = 7; Rs2D = 7; PCSrcE = 1;
    chk("branch_vs_lw", 4'hF, 3'b110, 2'b00, 2'b00, 1'b0);

    // plain wait: entry + 3 waiting cycles, then exit
    clr();
    MemReqM = 1;
    chk("mw_entry", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++)
      chk("mw_wait", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    mem_ready = 1;
    chk("mw_exit", 4'hF, 3'b000, 2'b00, 2'b00, 1'b0);
    MemReqM = 0; mem_ready = 0;
    chk("mw_run", 4'hF, 3'b000, 2'b00, 2'b00, 1'b0);

    // wait with load-use held in E; entry beats it, exit honours it
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; MemReqM = 1;
    chk("mw_lw_entry", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    chk("mw_lw_wait1", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    chk("mw_lw_wait2", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    mem_ready = 1;
    chk("mw_lw_exit", 4'b0011, 3'b010, 2'b00, 2'b00, 1'b0);

    // wait with taken branch held in E
    clr();
    PCSrcE = 1; MemReqM = 1;
    chk("mw_br_entry", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    chk("mw_br_wait", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    mem_ready = 1;
    chk("mw_br_exit", 4'hF, 3'b110, 2'b00, 2'b00, 1'b0);

    // timeout at 4 waiting cycles, sticky afterwards
    clr();
    MemReqM = 1;
    chk("to_entry", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("to_pre", 4'h0, 3'b001, 2'b00, 2'b00, 1'b0);
    chk("to_err", 4'h0, 3'b001, 2'b00, 2'b00, 1'b1);
    chk("to_err_hold", 4'h0, 3'b001, 2'b00, 2'b00, 1'b1);
    mem_ready = 1;
    chk("to_exit", 4'hF, 3'b000, 2'b00, 2'b00, 1'b1);
    MemReqM = 0; mem_ready = 0;
    chk("to_sticky", 4'hF, 3'b000, 2'b00, 2'b00, 1'b1);

    // async reset in the middle of a wait
    MemReqM = 1;
    chk("ar_entry", 4'h0, 3'b001, 2'b00, 2'b00, 1'b1);
    chk("ar_wait", 4'h0, 3'b001, 2'b00, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    q.push_back('{name: "ar_reset",
                  val: {4'hF, 3'b111, 2'b00, 2'b00, 1'b0}});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    MemReqM = 0; mem_ready = 0;
    chk("ar_run", 4'hF, 3'b000, 2'b00, 2'b00, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that drives the enable (`en`) and synchronous-clear (`rst`) inputs of the F/D, D/E, E/M and M/W pipeline registers.
- Produces execute-stage forwarding selects.
- Sequences multi-cycle data-memory waits with a registered FSM, including timeout detection.
- Sits beside the datapath and consumes register IDs and control bits already carried by the pipeline registers.

Parameters:
- ADDR_WIDTH, 5: register-index width.
- MEM_TIMEOUT, 255: MEM_WAIT cycle count at which `mem_err` is raised.
- CNT_WIDTH, 8: width of the wait counter; must satisfy 2^CNT_WIDTH-1 >= MEM_TIMEOUT.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `Rs1D`, `Rs2D`  in  ADDR_WIDTH each  source registers in decode
- `Rs1E`, `Rs2E`, `RdE`  in  ADDR_WIDTH each  source/destination registers in execute
- `RdM`, `RdW`  in  ADDR_WIDTH each  destination registers in memory/writeback
- `RegWriteM`, `RegWriteW`  in  3 each  writeback controls; nonzero means the stage writes
- `ResultSrcE`  in  2  value 2'b01 marks a load in execute
- `PCSrcE`  in  1  taken branch/jump resolved in execute
- `MemReqM`  in  1  load/store active in memory stage
- `mem_ready`  in  1  data memory completes the request this cycle
- `EnF`, `EnD`, `EnE`, `EnM`  out  1 each  pipeline register enables
- `FlushD`, `FlushE`, `FlushW`  out  1 each  synchronous clears to D, E, W registers
- `ForwardAE`, `ForwardBE`  out  2 each  ALU operand selects
- `mem_err`  out  1  sticky timeout flag

Behaviour:
- **Reset.** While `rst_n`=0: state=RUN, wait_cnt=0, `mem_err`=0. Outputs during reset: all Enables=1, `FlushD`=`FlushE`=`FlushW`=1, Forwards=00. Reset is asynchronous on assert and synchronous on release.
- **Forwarding** (combinational, all states). Evaluated per operand X∈{1,2}:
  - 10 (MEM) if `RegWriteM`!=0, `RdM`!=0 and `RdM`==`RsXE`;
  - else 01 (WB) if `RegWriteW`!=0, `RdW`!=0 and `RdW`==`RsXE`;
  - else 00. M has priority over W.
- **lwStall** = (`ResultSrcE`==2'b01) && `RdE`!=0 && (`RdE`==`Rs1D` || `RdE`==`Rs2D`).
- **State RUN:**
  - Default: all Enables=1, all Flushes=0.
  - Entering MEM_WAIT: if `MemReqM` && !`mem_ready`, next=MEM_WAIT. This cycle `EnF`=`EnD`=`EnE`=`EnM`=0 and `FlushW`=1 (bubble into W). Takes priority over lwStall and `PCSrcE`.
  - Load-use stall: else if lwStall && !`PCSrcE`: `EnF`=`EnD`=0, `FlushE`=1; exactly one bubble per occurrence.
  - Taken branch: else if `PCSrcE`: `FlushD`=`FlushE`=1 with all Enables=1 (flush wins over lwStall).
- **State MEM_WAIT:**
  - While !`mem_ready`: all Enables=0, `FlushW`=1, other Flushes=0. wait_cnt increments and saturates at 2^CNT_WIDTH-1.
  - Timeout: when wait_cnt==MEM_TIMEOUT-1 and !`mem_ready`, `mem_err`<=1. It stays set until reset; the state remains MEM_WAIT.
  - On `mem_ready`=1 (exit cycle): next=RUN, wait_cnt<=0, and outputs are evaluated with the RUN rules for lwStall/`PCSrcE` excluding the MEM_WAIT-entry rule.
  - `PCSrcE` and lwStall are held by the frozen E stage and act in the exit cycle.
- **Timing.** FSM transitions occur on `clk`; all outputs are combinational from state and inputs, giving zero added latency. x0 never forwards and never stalls.

Decomposition:
- **`hazard_pkg`:**
  - state enum {RUN, MEM_WAIT};
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - RESULT_MEM=2'b01.
- **Sub-module `forward_sel`:** one-operand forwarding comparator, instantiated twice (A, B).

Test Plan:
- **Forward priority.** `Rs1E`=5, `RdM`=5, `RegWriteM`=1, `RdW`=5, `RegWriteW`=1 -> `ForwardAE`=10. Then set `RegWriteM`=0 -> 01. Then set `Rs1E`=0 -> 00.
- **Load-use stall.** `ResultSrcE`=01, `RdE`=7, `Rs2D`=7 in RUN -> one cycle of `EnF`=`EnD`=0, `FlushE`=1. Next cycle, with E now a bubble -> all Enables=1.
- **Branch beats load-use.** Same as the load-use case plus `PCSrcE`=1 -> `FlushD`=`FlushE`=1, `EnF`=`EnD`=1.
- **Memory wait.** `MemReqM`=1, `mem_ready`=0 for 4 cycles then 1 -> Enables=0 and `FlushW`=1 on the entry cycle and the 3 following cycles. Exit cycle: all Enables=1. State back to RUN, wait_cnt=0.
- **Timeout.** MEM_TIMEOUT=4, `mem_ready` held 0 -> `mem_err` rises after 4 MEM_WAIT cycles and stays 1 after `mem_ready`=1. It clears only on `rst_n`=0.
- **Async reset mid-wait.** Drop `rst_n` asynchronously during MEM_WAIT -> immediate Enables=1, Flushes=1, `mem_err`=0. After release, state is RUN.
